// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared states, constants and helpers for the readout scheduler
package readout_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_SELECT,
    S_CAPTURE,
    S_SEND_HI,
    S_SEND_LO,
    S_ADVANCE,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Header, frame count and checksum plus two bytes per enabled pixel-bank.
  function automatic int unsigned frame_bytes(input int unsigned pixels, input logic [1:0] bank_en);
    return 32'd3 + 32'd2 * pixels * (32'(bank_en[0]) + 32'(bank_en[1]));
  endfunction

endpackage

// File: rtl/readout_byte_tx.sv
// rtl/readout_byte_tx.sv - registered byte output with valid/ready hold
module readout_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       fire
);

  assign fire = valid & ready;

  // A new load only arrives after a transfer or while idle, so data never moves under a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (abort) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/readout_scheduler.sv
// rtl/readout_scheduler.sv - frame sequencer streaming per-pixel periods as bytes
module readout_scheduler
  import readout_pkg::*;
#(
  parameter int PIXELS       = 64,
  parameter int COUNTER_BITS = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        ABORT,
  input  logic [1:0]                  BANK_EN,
  output logic [$clog2(PIXELS)-1:0]   PIX_SEL,
  output logic                        BANK_SEL,
  input  logic [COUNTER_BITS-1:0]     PERIOD_IN,
  output logic [7:0]                  OUT_DATA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic                        BUSY,
  output logic                        FRAME_DONE,
  output logic [7:0]                  FRAME_CNT
);

  localparam int PIX_W = $clog2(PIXELS);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  state_t           state_q;
  logic [PIX_W-1:0] pix_q;
  logic             bank_q;
  logic [1:0]       en_q;
  logic [7:0]       csum_q;
  logic [7:0]       period_lo_q;
  logic [7:0]       frame_cnt_q;
  logic             frame_done_q;

  logic             tx_load;
  logic [7:0]       tx_byte;
  logic             tx_fire;
  logic             last_slot;

  // Final slot: last pixel, and either the column bank or a row-only frame.
  assign last_slot = (pix_q == PIX_LAST) && (bank_q || !en_q[1]);

  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    if (!ABORT) begin
      case (state_q)
        S_IDLE: begin
          if (START && (BANK_EN != 2'b00)) begin
            tx_load = 1'b1;
            tx_byte = HDR_BYTE;
          end
        end
        S_HDR: begin
          if (tx_fire) begin
            tx_load = 1'b1;
            tx_byte = frame_cnt_q;
          end
        end
        S_CAPTURE: begin
          tx_load = 1'b1;
          tx_byte = PERIOD_IN[15:8];
        end
        S_SEND_HI: begin
          if (tx_fire) begin
            tx_load = 1'b1;
            tx_byte = period_lo_q;
          end
        end
        S_ADVANCE: begin
          if (last_slot) begin
            tx_load = 1'b1;
            tx_byte = csum_q;
          end
        end
        default: ;
      endcase
    end
  end

  readout_byte_tx u_tx (
    .clk       (CLK),
    .rst       (RST),
    .abort     (ABORT),
    .load      (tx_load),
    .load_data (tx_byte),
    .ready     (OUT_READY),
    .data      (OUT_DATA),
    .valid     (OUT_VALID),
    .fire      (tx_fire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      bank_q       <= 1'b0;
      en_q         <= 2'b00;
      csum_q       <= 8'h00;
      period_lo_q  <= 8'h00;
      frame_cnt_q  <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (ABORT) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (START && (BANK_EN != 2'b00)) begin
              state_q <= S_HDR;
              en_q    <= BANK_EN;
              pix_q   <= '0;
              bank_q  <= ~BANK_EN[0];
              csum_q  <= HDR_BYTE;
            end
          end
          S_HDR: begin
            if (tx_fire) begin
              state_q <= S_CNT;
              csum_q  <= csum_q ^ frame_cnt_q;
            end
          end
          S_CNT: begin
            if (tx_fire) state_q <= S_SELECT;
          end
          S_SELECT: state_q <= S_CAPTURE;
          S_CAPTURE: begin
            period_lo_q <= PERIOD_IN[7:0];
            csum_q      <= csum_q ^ PERIOD_IN[15:8];
            state_q     <= S_SEND_HI;
          end
          S_SEND_HI: begin
            if (tx_fire) begin
              state_q <= S_SEND_LO;
              csum_q  <= csum_q ^ period_lo_q;
            end
          end
          S_SEND_LO: begin
            if (tx_fire) state_q <= S_ADVANCE;
          end
          S_ADVANCE: begin
            if (last_slot) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_SELECT;
              if (!bank_q && en_q[1]) begin
                bank_q <= 1'b1;
              end else begin
                pix_q  <= pix_q + PIX_W'(1);
                bank_q <= ~en_q[0];
              end
            end
          end
          S_CSUM: begin
            if (tx_fire) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end
          end
          S_DONE: begin
            state_q     <= S_IDLE;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign PIX_SEL    = pix_q;
  assign BANK_SEL   = bank_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = frame_done_q;
  assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// tb/tb_readout_scheduler.sv - scoreboard bench for readout_scheduler
module tb_readout_scheduler;

  localparam int PIXELS = 4;
  localparam int PW     = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready;
  logic [1:0]    bank_en;
  logic [PW-1:0] pix_sel;
  logic          bank_sel;
  logic [15:0]   period_in;
  logic [7:0]    out_data;
  logic          out_valid, busy, frame_done;
  logic [7:0]    frame_cnt;
  logic          per_mode;

  always #5 clk = ~clk;

  // External period mux: constant 0x1234, or 0x0100*pixel + bank.
  assign period_in = per_mode ? {6'd0, pix_sel, 7'd0, bank_sel} : 16'h1234;

  readout_scheduler #(.PIXELS(PIXELS), .COUNTER_BITS(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .ABORT      (abort),
    .BANK_EN    (bank_en),
    .PIX_SEL    (pix_sel),
    .BANK_SEL   (bank_sel),
    .PERIOD_IN  (period_in),
    .OUT_DATA   (out_data),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .BUSY       (busy),
    .FRAME_DONE (frame_done),
    .FRAME_CNT  (frame_cnt)
  );

  typedef struct {
    logic [7:0]    data;
    logic          chk;
    logic          bank;
    logic [PW-1:0] pix;
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] fcnt_model = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [1:0] en);
    exp_t       e;
    logic [7:0] cs;
    logic [15:0] per;
    e.chk = 1'b0; e.bank = 1'b0; e.pix = '0;
    e.data = 8'hA5;     exp_q.push_back(e); cs = 8'hA5;
    e.data = fcnt_model; exp_q.push_back(e); cs ^= fcnt_model;
    for (int p = 0; p < PIXELS; p++) begin
      for (int b = 0; b < 2; b++) begin
        if (en[b]) begin
          per    = per_mode ? 16'(p * 256 + b) : 16'h1234;
          e.chk  = 1'b1;
          e.bank = b[0];
          e.pix  = PW'(p);
          e.data = per[15:8]; exp_q.push_back(e); cs ^= e.data;
          e.data = per[7:0];  exp_q.push_back(e); cs ^= e.data;
        end
      end
    end
    e.chk = 1'b0; e.data = cs; exp_q.push_back(e);
  endtask

  task automatic run_frame(input logic [1:0] en, input int pct, input bit noise, input int abort_idx);
    int         nbytes, cycles, nb;
    bit         done, stall;
    logic [7:0] hold, cnt0;
    exp_t       e;
    cnt0 = fcnt_model;
    nb   = int'(en[0]) + int'(en[1]);
    push_frame(en);
    start = 1'b1; bank_en = en;
    @(posedge clk); #1;
    start = 1'b0;
    nbytes = 0; cycles = 0; done = 1'b0; stall = 1'b0; hold = 8'h00;
    while (!done && cycles < 2000) begin
      if (frame_done) begin
        done  = 1'b1;
        start = 1'b0;
        check("done_cnt_hold", frame_cnt, cnt0);
        check("byte_count", nbytes, 3 + 2 * PIXELS * nb);
        if (pct == 100) check("frame_cycles", cycles, 3 + 5 * PIXELS * nb);
      end else begin
        out_ready = ($urandom_range(1, 100) <= pct);
        if (noise) begin
          start   = $urandom_range(0, 1) == 1;
          bank_en = 2'($urandom);
        end
        if (stall) check("stall_hold", {out_valid, out_data}, {1'b1, hold});
        if (out_valid && nbytes == abort_idx) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          check("abort_valid", out_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_cnt", frame_cnt, cnt0);
          exp_q.delete();
          out_ready = 1'b1;
          return;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", out_data, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("byte", out_data, e.data);
            if (e.chk) begin
              check("bank_sel", bank_sel, e.bank);
              check("pix_sel", pix_sel, e.pix);
            end
          end
          nbytes++;
        end
        stall = out_valid && !out_ready;
        hold  = out_data;
        @(posedge clk); #1;
        cycles++;
      end
    end
    if (!done) begin
      check("frame_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      fcnt_model++;
      check("idle_busy", busy, 0);
      check("cnt_inc", frame_cnt, fcnt_model);
      check("leftover", exp_q.size(), 0);
    end
    exp_q.delete();
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    bank_en = 2'b00; per_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_pix", pix_sel, 0);
    check("rst_bank", bank_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    start = 1'b1; bank_en = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_en0_busy", busy, 0);

    start = 1'b1; abort = 1'b1; bank_en = 2'b01;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_valid", out_valid, 0);

    per_mode = 1'b0; run_frame(2'b01, 100, 1'b0, -1);
    per_mode = 1'b1; run_frame(2'b11, 100, 1'b0, -1);
    per_mode = 1'b1; run_frame(2'b10, 100, 1'b0, -1);
    per_mode = 1'b0; run_frame(2'b01, 30, 1'b0, -1);
    per_mode = 1'b1; run_frame(2'b11, 30, 1'b0, -1);
    per_mode = 1'b1; run_frame(2'b11, 50, 1'b1, -1);

    per_mode = 1'b0; run_frame(2'b01, 100, 1'b0, 7);
    run_frame(2'b01, 100, 1'b0, -1);

    while (fcnt_model != 8'h00) run_frame(2'b01, 100, 1'b0, -1);
    check("wrap_cnt", frame_cnt, 0);
    start = 1'b1; bank_en = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    check("wrap_en0_busy", busy, 0);

    start = 1'b1; bank_en = 2'b11; per_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    fcnt_model = 8'h00;
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_pix", pix_sel, 0);
    check("mrst_bank", bank_sel, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", frame_done, 0);
    check("mrst_cnt", frame_cnt, 0);

    run_frame(2'b11, 30, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
